// File: rtl/io_capture_buffer.sv
// io_capture_buffer: delayed startIO strobe + FIFO capture of CPU output words (outFlag/out) drained over rd_valid/rd_ready, with captured/done/overflow status
module io_capture_buffer #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 16,
  parameter int START_DELAY = 10,
  parameter int TARGET_COUNT = 750,
  parameter int COUNT_W = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     outFlag,
  input  logic [WIDTH-1:0]         out,
  output logic                     startIO,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic [COUNT_W-1:0]       captured,
  output logic                     done,
  output logic                     overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int DW = START_DELAY > 1 ? $clog2(START_DELAY) : 1;
  typedef enum logic [1:0] {DELAY, RUN, DONE} state_t;
  state_t state, state_n;
  logic [DW-1:0] dcnt;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic push, pop, accept, last;
  assign startIO = state != DELAY;
  assign done = state == DONE;
  assign rd_valid = level != '0;
  assign rd_data = mem[rp];
  always_comb begin
    push = outFlag && state == RUN;
    pop = rd_valid && rd_ready;
    accept = push && (level != LW'(DEPTH) || pop);
    last = accept && captured == COUNT_W'(TARGET_COUNT - 1);
    state_n = (state == DELAY && dcnt == DW'(START_DELAY - 1)) ? RUN : last ? DONE : state;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= DELAY;
      dcnt <= '0;
      wp <= '0;
      rp <= '0;
      level <= '0;
      captured <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_n;
      if (state == DELAY) dcnt <= dcnt + 1'b1;
      if (accept) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      level <= level + LW'(accept) - LW'(pop);
      captured <= captured + COUNT_W'(accept);
      overflow <= overflow | (push & ~accept);
    end
  end
  always_ff @(posedge clock) begin
    if (accept) mem[wp] <= out;
  end
endmodule

// File: tb/tb_io_capture_buffer.sv
// tb_io_capture_buffer: directed scenarios plus randomized traffic checked every cycle against a queue-based model
module tb_io_capture_buffer;
  localparam int WIDTH = 24;
  localparam int DEPTH = 4;
  localparam int START_DELAY = 10;
  localparam int TARGET = 12;
  localparam int COUNT_W = 16;
  logic clock = 0;
  logic reset = 1;
  logic outFlag = 0;
  logic [WIDTH-1:0] out = '0;
  logic rd_ready = 0;
  logic startIO, rd_valid, done, overflow;
  logic [WIDTH-1:0] rd_data;
  logic [$clog2(DEPTH):0] level;
  logic [COUNT_W-1:0] captured;
  int n_run = 0;
  int n_fail = 0;
  logic [WIDTH-1:0] m_q[$];
  int m_cnt = 0;
  int m_cap = 0;
  bit m_ovf = 0;
  bit m_done = 0;
  bit armed = 0;
  io_capture_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .START_DELAY(START_DELAY),
    .TARGET_COUNT(TARGET), .COUNT_W(COUNT_W)) dut (
    .clock(clock), .reset(reset), .outFlag(outFlag), .out(out),
    .startIO(startIO), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .level(level), .captured(captured), .done(done), .overflow(overflow));
  always #5 clock = ~clock;
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
    end
  endtask
  always @(posedge clock) begin
    bit run, pop, push, acc;
    if (reset) begin
      m_q.delete();
      m_cnt = 0;
      m_cap = 0;
      m_ovf = 0;
      m_done = 0;
      armed = 1;
    end else begin
      run = m_cnt >= START_DELAY && !m_done;
      pop = m_q.size() > 0 && rd_ready;
      push = outFlag && run;
      acc = push && (m_q.size() < DEPTH || pop);
      if (pop) void'(m_q.pop_front());
      if (acc) begin
        m_q.push_back(out);
        m_cap++;
        if (m_cap == TARGET) m_done = 1;
      end
      if (push && !acc) m_ovf = 1;
      if (m_cnt < START_DELAY) m_cnt++;
    end
  end
  always @(negedge clock) begin
    if (armed) begin
      chk("m_startIO", 32'(startIO), 32'(m_cnt >= START_DELAY));
      chk("m_rd_valid", 32'(rd_valid), 32'(m_q.size() > 0));
      chk("m_level", 32'(level), 32'(m_q.size()));
      chk("m_captured", 32'(captured), 32'(m_cap));
      chk("m_done", 32'(done), 32'(m_done));
      chk("m_overflow", 32'(overflow), 32'(m_ovf));
      if (m_q.size() > 0) chk("m_rd_data", 32'(rd_data), 32'(m_q[0]));
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    logic [WIDTH-1:0] exp4 [4];
    int pf, pr;
    exp4 = '{24'h0000A1, 24'h0000A2, 24'h0000A3, 24'hABCDEF};
    repeat (2) @(negedge clock);
    reset = 0;
    for (int i = 0; i < START_DELAY; i++) begin
      chk("delay_startIO", 32'(startIO), 0);
      outFlag = 1;
      out = WIDTH'(i + 24'h50);
      @(negedge clock);
    end
    outFlag = 0;
    chk("start_startIO", 32'(startIO), 1);
    chk("start_level", 32'(level), 0);
    for (int i = 1; i <= 5; i++) begin
      outFlag = 1;
      out = WIDTH'(i);
      rd_ready = 1;
      @(negedge clock);
      chk("seq_rd_data", 32'(rd_data), 32'(i));
      chk("seq_level", 32'(level), 1);
    end
    outFlag = 0;
    @(negedge clock);
    chk("seq_captured", 32'(captured), 5);
    chk("seq_empty", 32'(level), 0);
    rd_ready = 0;
    for (int i = 0; i < 5; i++) begin
      outFlag = 1;
      out = WIDTH'(24'h100 + i);
      @(negedge clock);
    end
    outFlag = 0;
    chk("ovf_level", 32'(level), 4);
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_captured", 32'(captured), 9);
    for (int i = 0; i < 4; i++) begin
      chk("ovf_drain", 32'(rd_data), 32'(24'h100 + i));
      rd_ready = 1;
      @(negedge clock);
    end
    rd_ready = 0;
    chk("ovf_drained", 32'(rd_valid), 0);
    for (int i = 0; i < 2; i++) begin
      outFlag = 1;
      out = WIDTH'(24'h300 + i);
      @(negedge clock);
    end
    outFlag = 0;
    chk("rst_pre_level", 32'(level), 2);
    reset = 1;
    @(negedge clock);
    reset = 0;
    chk("rst_outputs", {26'd0, startIO, rd_valid, |level, |captured, done, overflow}, 0);
    for (int i = 0; i < START_DELAY; i++) begin
      chk("rst_delay", 32'(startIO), 0);
      @(negedge clock);
    end
    chk("rst_start", 32'(startIO), 1);
    for (int i = 0; i < 4; i++) begin
      outFlag = 1;
      out = WIDTH'(24'hA0 + i);
      @(negedge clock);
    end
    out = 24'hABCDEF;
    rd_ready = 1;
    @(negedge clock);
    outFlag = 0;
    rd_ready = 0;
    chk("full_level", 32'(level), 4);
    chk("full_overflow", 32'(overflow), 0);
    for (int i = 0; i < 4; i++) begin
      chk("full_drain", 32'(rd_data), 32'(exp4[i]));
      rd_ready = 1;
      @(negedge clock);
    end
    chk("full_captured", 32'(captured), 5);
    for (int i = 0; i < 9; i++) begin
      outFlag = 1;
      out = WIDTH'(24'h200 + i);
      @(negedge clock);
    end
    outFlag = 0;
    @(negedge clock);
    chk("tgt_done", 32'(done), 1);
    chk("tgt_captured", 32'(captured), TARGET);
    chk("tgt_overflow", 32'(overflow), 0);
    chk("tgt_empty", 32'(level), 0);
    rd_ready = 0;
    for (int e = 0; e < 8; e++) begin
      reset = 1;
      @(negedge clock);
      reset = 0;
      pf = $urandom_range(20, 90);
      pr = $urandom_range(10, 90);
      for (int c = 0; c < 300; c++) begin
        outFlag = $urandom_range(0, 99) < pf;
        rd_ready = $urandom_range(0, 99) < pr;
        out = WIDTH'($urandom);
        reset = $urandom_range(0, 149) == 0;
        @(negedge clock);
      end
    end
    reset = 0;
    outFlag = 0;
    @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
